rs_out_fmt: RTL and testbench

RS_OUT_FMT -- requirements
Module: rs_out_fmt

---
 rtl/rs_pkg.sv | 16 +
 rtl/rs_out_buf.sv | 56 +++++
 rtl/rs_out_fmt.sv | 199 +++++++++++++++++++
 tb/tb_rs_out_fmt.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared constants and FSM state type for the RS output formatter.
package rs_pkg;

  localparam int unsigned CW_WORDS   = 24;
  localparam int unsigned CW_BEATS   = 12;
  localparam int unsigned OBUF_DEPTH = 16;
  localparam int unsigned OBUF_W     = 131;
  localparam int unsigned CREDIT_MAX = OBUF_DEPTH - CW_BEATS;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPop   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/rs_out_buf.sv
// 16 x 131 synchronous FIFO for formatted output beats; head entry drives rdata_o.
module rs_out_buf
  import rs_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [OBUF_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [OBUF_W-1:0] rdata_o,
  output logic [4:0]        count_o,
  output logic              empty_o
);

  logic [OBUF_W-1:0] mem_q [OBUF_DEPTH];
  logic [3:0]        wr_ptr_q, wr_ptr_d;
  logic [3:0]        rd_ptr_q, rd_ptr_d;
  logic [4:0]        count_q, count_d;
  logic              do_pop;

  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // Gate the head so an empty buffer presents all-zero beat fields.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 4'd1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 4'd1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push_i, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rs_out_fmt.sv
// Pops corrected RS codewords (24 x 64b) and emits 12 x 128b beats with sof/eof framing.
// Optional statistics counters are built when RS_OUT_FMT_STAT_EN is defined.
module rs_out_fmt
  import rs_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         dec_done,
  output logic         pop_data_ena,
  input  logic         rs_pop_data_vld,
  input  logic [63:0]  rs_pop_data,
  input  logic         rs_pop_isos,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [127:0] out_data,
  output logic         out_sync,
  output logic         out_sof,
  output logic         out_eof,
  output logic         err_ovf,
  output logic         err_sync
`ifdef RS_OUT_FMT_STAT_EN
  ,
  output logic [31:0]  stat_cw_cnt,
  output logic [31:0]  stat_beat_cnt
`endif
);

  state_e      state_q, state_d;
  logic        pop_ena_q, pop_ena_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [1:0]  pend_q, pend_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_sync_q, err_sync_d;
  logic [4:0]  rx_cnt_q, rx_cnt_d;
  logic [63:0] even_q, even_d;
  logic        even_sync_q, even_sync_d;

  logic [4:0]        occ;
  logic [5:0]        occ_eff;
  logic              buf_empty;
  logic              credit_ok;
  logic              burst_start;
  logic              cap;
  logic              wr;
  logic              xfer;
  logic [OBUF_W-1:0] wdata;
  logic [OBUF_W-1:0] rdata;

  // In DRAIN the last beat of the previous codeword is still being written, so count it.
  assign occ_eff     = {1'b0, occ} + 6'(state_q == StDrain);
  assign credit_ok   = (occ_eff <= 6'(CREDIT_MAX));
  // Starting from DRAIN keeps the inter-burst gap at one cycle.
  assign burst_start = ((state_q == StIdle) || (state_q == StDrain)) && credit_ok &&
                       ((pend_q != 2'd0) || dec_done);

  // Words arrive one cycle after each pop: POP word-count 1..23 and the DRAIN cycle.
  assign cap   = rs_pop_data_vld &&
                 (((state_q == StPop) && (wcnt_q != 5'd0)) || (state_q == StDrain));
  assign wr    = cap && rx_cnt_q[0];
  assign wdata = {even_q, rs_pop_data, even_sync_q,
                  (rx_cnt_q == 5'd1), (rx_cnt_q == 5'(CW_WORDS - 1))};

  always_comb begin
    pend_d    = pend_q;
    err_ovf_d = err_ovf_q;
    if (dec_done && !burst_start) begin
      if (pend_q == 2'd3) begin
        err_ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 2'd1;
      end
    end else if (!dec_done && burst_start) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pop_ena_d = pop_ena_q;
    wcnt_d    = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (burst_start) begin
          state_d   = StPop;
          pop_ena_d = 1'b1;
          wcnt_d    = 5'd0;
        end
      end
      StPop: begin
        if (wcnt_q == 5'(CW_WORDS - 1)) begin
          state_d   = StDrain;
          pop_ena_d = 1'b0;
          wcnt_d    = 5'd0;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      StDrain: begin
        if (burst_start) begin
          state_d   = StPop;
          pop_ena_d = 1'b1;
          wcnt_d    = 5'd0;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        pop_ena_d = 1'b0;
        wcnt_d    = 5'd0;
      end
    endcase
  end

  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    even_d      = even_q;
    even_sync_d = even_sync_q;
    err_sync_d  = err_sync_q;
    if (cap) begin
      rx_cnt_d = (rx_cnt_q == 5'(CW_WORDS - 1)) ? 5'd0 : rx_cnt_q + 5'd1;
      if (!rx_cnt_q[0]) begin
        even_d      = rs_pop_data;
        even_sync_d = rs_pop_isos;
      end else if (rs_pop_isos != even_sync_q) begin
        err_sync_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      pop_ena_q   <= 1'b0;
      wcnt_q      <= '0;
      pend_q      <= '0;
      err_ovf_q   <= 1'b0;
      err_sync_q  <= 1'b0;
      rx_cnt_q    <= '0;
      even_q      <= '0;
      even_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_ena_q   <= pop_ena_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      err_ovf_q   <= err_ovf_d;
      err_sync_q  <= err_sync_d;
      rx_cnt_q    <= rx_cnt_d;
      even_q      <= even_d;
      even_sync_q <= even_sync_d;
    end
  end

  rs_out_buf u_out_buf (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (wr),
    .wdata_i (wdata),
    .pop_i   (xfer),
    .rdata_o (rdata),
    .count_o (occ),
    .empty_o (buf_empty)
  );

  assign out_vld      = !buf_empty;
  assign xfer         = out_vld && out_rdy;
  assign out_data     = rdata[130:3];
  assign out_sync     = rdata[2];
  assign out_sof      = rdata[1];
  assign out_eof      = rdata[0];
  assign pop_data_ena = pop_ena_q;
  assign err_ovf      = err_ovf_q;
  assign err_sync     = err_sync_q;

`ifdef RS_OUT_FMT_STAT_EN
  logic [31:0] stat_cw_q, stat_cw_d;
  logic [31:0] stat_beat_q, stat_beat_d;

  always_comb begin
    stat_cw_d   = stat_cw_q + 32'(xfer && out_eof);
    stat_beat_d = stat_beat_q + 32'(xfer);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cw_q   <= '0;
      stat_beat_q <= '0;
    end else begin
      stat_cw_q   <= stat_cw_d;
      stat_beat_q <= stat_beat_d;
    end
  end

  assign stat_cw_cnt   = stat_cw_q;
  assign stat_beat_cnt = stat_beat_q;
`endif

endmodule

// File: tb/tb_rs_out_fmt.sv
// Directed bench for rs_out_fmt with a behavioural upstream FIFO responder.
module tb_rs_out_fmt;

  logic         clk = 1'b0;
  logic         rstn;
  logic         dec_done;
  logic         pop_data_ena;
  logic         rs_pop_data_vld;
  logic [63:0]  rs_pop_data;
  logic         rs_pop_isos;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] out_data;
  logic         out_sync;
  logic         out_sof;
  logic         out_eof;
  logic         err_ovf;
  logic         err_sync;
`ifdef RS_OUT_FMT_STAT_EN
  logic [31:0]  stat_cw_cnt;
  logic [31:0]  stat_beat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int word_k = 0;
  int burst_id = 0;
  bit sync_bad = 1'b0;
  logic pop_prev = 1'b0;

  logic [127:0] b_data[$];
  bit           b_sync[$];
  bit           b_sof[$];
  bit           b_eof[$];
  int           pop_cyc[$];

  rs_out_fmt dut (
    .clk             (clk),
    .rstn            (rstn),
    .dec_done        (dec_done),
    .pop_data_ena    (pop_data_ena),
    .rs_pop_data_vld (rs_pop_data_vld),
    .rs_pop_data     (rs_pop_data),
    .rs_pop_isos     (rs_pop_isos),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_data        (out_data),
    .out_sync        (out_sync),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .err_ovf         (err_ovf),
    .err_sync        (err_sync)
`ifdef RS_OUT_FMT_STAT_EN
    ,
    .stat_cw_cnt     (stat_cw_cnt),
    .stat_beat_cnt   (stat_beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkword(input int b, input int k);
    return {16'hB5B5, b[15:0], 16'h5A5A, k[15:0]};
  endfunction

  function automatic logic iso_of(input int k);
    if (sync_bad && k == 4) return 1'b1;
    if (sync_bad && k == 5) return 1'b0;
    return k[1];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Upstream FIFO: data valid one cycle after each pop request.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rstn) begin
      rs_pop_data_vld = 1'b0;
      rs_pop_data     = '0;
      rs_pop_isos     = 1'b0;
      word_k          = 0;
      burst_id        = 0;
    end else if (pop_prev) begin
      rs_pop_data_vld = 1'b1;
      rs_pop_data     = mkword(burst_id, word_k);
      rs_pop_isos     = iso_of(word_k);
      word_k++;
      if (word_k == 24) begin
        word_k = 0;
        burst_id++;
      end
    end else begin
      rs_pop_data_vld = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    pop_prev = rstn && pop_data_ena;
    if (rstn && pop_data_ena) pop_cyc.push_back(cyc);
    if (rstn && out_vld && out_rdy) begin
      b_data.push_back(out_data);
      b_sync.push_back(out_sync);
      b_sof.push_back(out_sof);
      b_eof.push_back(out_eof);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    b_data.delete();
    b_sync.delete();
    b_sof.delete();
    b_eof.delete();
    pop_cyc.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rstn = 1'b0;
    dec_done = 1'b0;
    sync_bad = 1'b0;
    out_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pop"}, 128'(pop_data_ena), 128'd0);
    chk({tag, "_vld"}, 128'(out_vld), 128'd0);
    chk({tag, "_data"}, out_data, 128'd0);
    chk({tag, "_flags"}, 128'({out_sync, out_sof, out_eof}), 128'd0);
    chk({tag, "_err"}, 128'({err_ovf, err_sync}), 128'd0);
    clear_logs();
    rstn = 1'b1;
  endtask

  task automatic pulse(output int t);
    @(posedge clk);
    #1 dec_done = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 dec_done = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int c = 0;
    while (b_data.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    chk(tag, 128'(b_data.size()), 128'(n));
  endtask

  task automatic check_beats(input int n, input bit bad0, input string tag);
    for (int i = 0; i < n && i < b_data.size(); i++) begin
      int b = i % 12;
      int w = i / 12;
      logic [127:0] exp_d = {mkword(w, 2 * b), mkword(w, 2 * b + 1)};
      bit exp_s = (bad0 && w == 0 && b == 2) ? 1'b1 : b[0];
      chk($sformatf("%s_data%0d", tag, i), b_data[i], exp_d);
      chk($sformatf("%s_sync%0d", tag, i), 128'(b_sync[i]), 128'(exp_s));
      chk($sformatf("%s_sof%0d", tag, i), 128'(b_sof[i]), 128'(b == 0));
      chk($sformatf("%s_eof%0d", tag, i), 128'(b_eof[i]), 128'(b == 11));
    end
  endtask

  initial begin
    int t;
    int r;
    rstn            = 1'b0;
    dec_done        = 1'b0;
    out_rdy         = 1'b1;
    rs_pop_data_vld = 1'b0;
    rs_pop_data     = '0;
    rs_pop_isos     = 1'b0;

    // Single codeword, out_rdy held high.
    do_reset("rst0");
    pulse(t);
    wait_beats(12, 200, "a_cnt");
    chk("a_popcnt", 128'(pop_cyc.size()), 128'd24);
    if (pop_cyc.size() == 24) begin
      chk("a_popfirst", 128'(pop_cyc[0]), 128'(t + 1));
      chk("a_poplast", 128'(pop_cyc[23]), 128'(t + 24));
    end
    check_beats(12, 1'b0, "a");

    // Three back-to-back dec_done pulses.
    do_reset("rst1");
    @(posedge clk);
    #1 dec_done = 1'b1;
    t = cyc;
    repeat (3) @(posedge clk);
    #1 dec_done = 1'b0;
    wait_beats(36, 400, "b_cnt");
    chk("b_popcnt", 128'(pop_cyc.size()), 128'd72);
    if (pop_cyc.size() == 72) begin
      chk("b_popfirst", 128'(pop_cyc[0]), 128'(t + 1));
      chk("b_run0", 128'(pop_cyc[23]), 128'(pop_cyc[0] + 23));
      chk("b_gap1", 128'(pop_cyc[24]), 128'(pop_cyc[23] + 2));
      chk("b_run1", 128'(pop_cyc[47]), 128'(pop_cyc[24] + 23));
      chk("b_gap2", 128'(pop_cyc[48]), 128'(pop_cyc[47] + 2));
      chk("b_run2", 128'(pop_cyc[71]), 128'(pop_cyc[48] + 23));
    end
    chk("b_ovf", 128'(err_ovf), 128'd0);
    check_beats(36, 1'b0, "b");

    // Backpressure: second codeword held until occupancy drops to 4.
    do_reset("rst2");
    out_rdy = 1'b0;
    pulse(t);
    repeat (5) @(posedge clk);
    pulse(t);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("c_held_popcnt", 128'(pop_cyc.size()), 128'd24);
    chk("c_held_vld", 128'(out_vld), 128'd1);
    chk("c_held_data", out_data, {mkword(0, 0), mkword(0, 1)});
    chk("c_held_sof", 128'(out_sof), 128'd1);
    @(posedge clk);
    #1 out_rdy = 1'b1;
    r = cyc;
    wait_beats(24, 300, "c_cnt");
    chk("c_popcnt", 128'(pop_cyc.size()), 128'd48);
    if (pop_cyc.size() == 48) begin
      chk("c_resume", 128'(pop_cyc[24]), 128'(r + 9));
    end
    check_beats(24, 1'b0, "c");

    // Pending saturation and overflow flag.
    do_reset("rst3");
    pulse(t);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      pulse(t);
      if (i == 2) chk("d_ovf_at3", 128'(err_ovf), 128'd0);
      if (i == 3) chk("d_ovf_at4", 128'(err_ovf), 128'd1);
    end
    wait_beats(48, 400, "d_cnt");
    chk("d_popcnt", 128'(pop_cyc.size()), 128'd96);
    chk("d_ovf_sticky", 128'(err_ovf), 128'd1);
    check_beats(48, 1'b0, "d");

    // Sync mismatch on words 4/5.
    do_reset("rst4");
    sync_bad = 1'b1;
    chk("e_sync_pre", 128'(err_sync), 128'd0);
    pulse(t);
    wait_beats(12, 200, "e_cnt");
    chk("e_errsync", 128'(err_sync), 128'd1);
    check_beats(12, 1'b1, "e");
    sync_bad = 1'b0;

    // Reset in the middle of a burst, then a fresh codeword.
    do_reset("rst5");
    pulse(t);
    r = 0;
    while (word_k < 11 && r < 100) begin
      @(posedge clk);
      #2;
      r++;
    end
    chk("f_reached_w10", 128'(word_k), 128'd11);
    rstn = 1'b0;
    @(negedge clk);
    chk("f_rst_pop", 128'(pop_data_ena), 128'd0);
    chk("f_rst_vld", 128'(out_vld), 128'd0);
    chk("f_rst_data", out_data, 128'd0);
    chk("f_rst_flags", 128'({out_sync, out_sof, out_eof, err_ovf, err_sync}), 128'd0);
    @(posedge clk);
    @(negedge clk);
    clear_logs();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    chk("f_idle_pop", 128'(pop_data_ena), 128'd0);
    pulse(t);
    wait_beats(12, 200, "f_cnt");
    chk("f_popcnt", 128'(pop_cyc.size()), 128'd24);
    check_beats(12, 1'b0, "f");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
